// File: rtl/dbus_arbiter.sv
// Two-manager, one-subordinate data-bus arbiter: round-robin grant, single-beat transfers, fixed-latency read return.
// Optional stall counters are compiled in when DBUS_ARB_PERF_EN is defined.
module dbus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic [STRB_WIDTH-1:0] m0_wstrb_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  input  logic [STRB_WIDTH-1:0] m1_wstrb_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic [ADDR_WIDTH-1:0] s_awaddr_o,
  output logic                  s_wvalid_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  output logic [STRB_WIDTH-1:0] s_wstrb_o,
  output logic                  s_arvalid_o,
  output logic [ADDR_WIDTH-1:0] s_araddr_o,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  output logic [ADDR_WIDTH-1:0] s_addr_o
`ifdef DBUS_ARB_PERF_EN
  ,
  output logic [31:0]           m0_stall_cnt_o,
  output logic [31:0]           m1_stall_cnt_o
`endif
);

  logic                  last_gnt;
  logic                  winner;
  logic                  grant;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [STRB_WIDTH-1:0] win_wstrb;
  logic [RD_LAT-1:0]     rd_vld;
  logic [RD_LAT-1:0]     rd_id;

  // On conflict the manager not granted most recently wins.
  always_comb begin
    grant = m0_req_i | m1_req_i;
    if (m0_req_i && m1_req_i) winner = ~last_gnt;
    else                      winner = m1_req_i;
  end

  assign m0_gnt_o = m0_req_i & ~winner;
  assign m1_gnt_o = m1_req_i &  winner;

  always_comb begin
    win_we    = winner ? m1_we_i    : m0_we_i;
    win_addr  = winner ? m1_addr_i  : m0_addr_i;
    win_wdata = winner ? m1_wdata_i : m0_wdata_i;
    win_wstrb = winner ? m1_wstrb_i : m0_wstrb_i;
    s_wvalid_o  = grant &  win_we;
    s_arvalid_o = grant & ~win_we;
    s_addr_o    = grant ? win_addr  : '0;
    s_awaddr_o  = grant ? win_addr  : '0;
    s_araddr_o  = grant ? win_addr  : '0;
    s_wdata_o   = grant ? win_wdata : '0;
    s_wstrb_o   = (grant && win_we) ? win_wstrb : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    last_gnt <= 1'b1;
    else if (grant) last_gnt <= winner;
  end

  // Read-return tag pipeline; the last stage lines up with s_rdata_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld <= '0;
      rd_id  <= '0;
    end else begin
      rd_vld[0] <= s_arvalid_o;
      rd_id[0]  <= winner;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        rd_id[i]  <= rd_id[i-1];
      end
    end
  end

  assign m0_rvalid_o = rd_vld[RD_LAT-1] & ~rd_id[RD_LAT-1];
  assign m1_rvalid_o = rd_vld[RD_LAT-1] &  rd_id[RD_LAT-1];
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

`ifdef DBUS_ARB_PERF_EN
  // Saturating counts of cycles spent requesting without a grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m0_stall_cnt_o <= '0;
      m1_stall_cnt_o <= '0;
    end else begin
      if (m0_req_i && !m0_gnt_o && (m0_stall_cnt_o != '1))
        m0_stall_cnt_o <= m0_stall_cnt_o + 32'd1;
      if (m1_req_i && !m1_gnt_o && (m1_stall_cnt_o != '1))
        m1_stall_cnt_o <= m1_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-manager to one-subordinate arbiter for the data bus. Shares a single data memory/peripheral port between manager 0 (core load/store unit) and manager 1 (debug/loader).
- Round-robin grant, single-beat transfers, no backpressure from the subordinate.
- Routes fixed-latency read data back to whichever manager issued the read.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; STRB_WIDTH = DATA_WIDTH/8 (derived, not overridable)
- RD_LAT, 1, subordinate read latency in cycles, legal range 1..4

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- m0_req_i  input  1  manager 0 request
- m0_we_i  input  1  manager 0 write (1) / read (0)
- m0_addr_i  input  ADDR_WIDTH  manager 0 address
- m0_wdata_i  input  DATA_WIDTH  manager 0 write data
- m0_wstrb_i  input  STRB_WIDTH  manager 0 byte strobes
- m0_gnt_o  output  1  manager 0 request accepted this cycle
- m0_rvalid_o  output  1  manager 0 read data valid
- m0_rdata_o  output  DATA_WIDTH  manager 0 read data
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same as manager 0, for manager 1
- s_awaddr_o  output  ADDR_WIDTH  subordinate write address
- s_wvalid_o  output  1  subordinate write strobe
- s_wdata_o  output  DATA_WIDTH  subordinate write data
- s_wstrb_o  output  STRB_WIDTH  subordinate byte strobes
- s_arvalid_o  output  1  subordinate read request
- s_araddr_o  output  ADDR_WIDTH  subordinate read address
- s_rdata_i  input  DATA_WIDTH  subordinate read data, valid RD_LAT cycles after s_arvalid_o
- s_addr_o  output  ADDR_WIDTH  debug: granted address, read or write

Behaviour:
- One clock domain, clk_i. Reset rst_ni is asynchronous and active-low.
- Arbitration is combinational in the same cycle.
  - Exactly one request: that manager is granted.
  - Both requesting: the manager not granted most recently wins.
- State register last_gnt.
  - Reset value: 1, so m0 wins the first conflict.
  - Updates on every cycle with a grant, to the granted index.
  - Holds when neither manager requests.
- mX_gnt_o = mX_req_i & (winner == X). Never both high.
- A request not granted must be held by its manager, with stable attributes, until granted. The arbiter does not check this.
- Subordinate side is a pure mux of the winner.
  - s_wvalid_o = grant & we.
  - s_arvalid_o = grant & ~we.
  - s_awaddr_o, s_araddr_o and s_addr_o = winner address.
  - s_wdata_o = winner wdata.
  - s_wstrb_o = winner wstrb on writes, 0 on reads.
  - With no grant, all s_* outputs are 0.
- Read return pipeline: RD_LAT-deep shift register of {valid, id}.
  - Stage 0 loads {s_arvalid_o, winner}.
  - At the last stage, mX_rvalid_o = valid & (id == X).
  - mX_rdata_o = s_rdata_i when mX_rvalid_o is high, else 0.
  - Throughput: one read per cycle, back-to-back and interleaved between managers.
- Reset values: all valid bits 0, both rvalid_o 0, last_gnt 1. Gnt and s_* outputs follow the request inputs combinationally, so they are 0 when all req are 0.
- Reset asserted mid-read: pending returns are discarded, and no rvalid_o pulses after release for reads issued before reset.
- A write followed by a read of the same address in the next cycle is passed through in order. Ordering is the subordinate's responsibility.
- Unused address/data bits get no special treatment. No alignment checks.

Optional Feature:
- Macro DBUS_ARB_PERF_EN.
- When defined:
  - Adds outputs m0_stall_cnt_o and m1_stall_cnt_o, 32 bits each.
  - Each counts cycles with mX_req_i=1 and mX_gnt_o=0, saturating at 0xFFFF_FFFF.
  - Both counters reset to 0.
- When undefined: these ports and their registers do not exist, and arbitration behaviour is identical.

Test Plan:
- Reset, then m0 read addr 0x100 alone, subordinate returns 0xDEADBEEF -> m0_gnt_o=1 in cycle 0; s_arvalid_o=1, s_araddr_o=0x100; m0_rvalid_o=1 with rdata 0xDEADBEEF in cycle RD_LAT; m1_rvalid_o stays 0.
- Both request continuously for 4 cycles from reset -> grant order m0,m1,m0,m1. With m1 writing 0x55 strobe 0x1: s_wvalid_o=1 and s_wstrb_o=0x1 only on m1 cycles.
- Interleaved back-to-back reads, m0@0x0 then m1@0x4, RD_LAT=2, data 0x11 then 0x22 -> m0 gets 0x11 in cycle 2, m1 gets 0x22 in cycle 3, no cross-delivery.
- Idle cycle between grants (m1 last granted, then idle, then both request) -> m0 wins; last_gnt is held across the idle cycle.
- rst_ni asserted one cycle after an m1 read with RD_LAT=3 -> no m1_rvalid_o after reset release; the next conflict is won by m0.
- With DBUS_ARB_PERF_EN defined, both requesting for 6 cycles -> m0_stall_cnt_o=3, m1_stall_cnt_o=3. Without the macro the bench compiles without the counter ports.
